// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter
// Round-robin arbiter that merges NUM_REQ user-kernel output streams onto one
// leaf interface output port. One requester owns the port for a burst of up to
// MAX_BURST beats. Beats pass through a single registered output stage that is
// tagged with the index of the source requester.
//
// Optional feature: define LEAF_ARB_STATS_EN to add the 32-bit beat_count
// port, which counts output transfers.
//
// Handshake semantics (all streams): a beat transfers on a rising edge where
// vld and ack are both high. A producer holds vld and data stable until the
// beat transfers. An ack may depend combinationally on the consumer's ack
// (din_req_ack follows dout_ack), but no vld ever depends on an ack.

module leaf_out_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int MAX_BURST    = 16,
  parameter int GRANT_BITS   = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req_data,
  input  logic [NUM_REQ-1:0]              din_req_vld,
  output logic [NUM_REQ-1:0]              din_req_ack,
  output logic [PAYLOAD_BITS-1:0]         dout_data,
  output logic                            dout_vld,
  input  logic                            dout_ack,
  output logic [GRANT_BITS-1:0]           dout_src
`ifdef LEAF_ARB_STATS_EN
  ,
  output logic [31:0]                     beat_count
`endif
);

  localparam int                    CNT_W    = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [GRANT_BITS-1:0] LAST_RST = GRANT_BITS'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                  state;
  logic [GRANT_BITS-1:0]   grant;
  logic [GRANT_BITS-1:0]   last;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;

  logic [PAYLOAD_BITS-1:0] req_data [NUM_REQ];
  logic                    can_load;
  logic                    grant_vld;
  logic                    accept;
  logic                    win_found;
  logic [GRANT_BITS-1:0]   winner;
  logic [GRANT_BITS-1:0]   idx;

  // Split the flat requester data bus into one word per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data[g] = din_req_data[g*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  // Output stage is free when empty or when its held beat leaves this cycle.
  assign can_load  = !dout_vld || dout_ack;
  assign grant_vld = din_req_vld[grant];
  assign accept    = (state == BURST) && grant_vld && can_load;
  assign cnt_nxt   = cnt + CNT_W'(1);

  // Round-robin search: first valid requester after the last one granted.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GRANT_BITS'((int'(last) + i) % NUM_REQ);
      if (!win_found && din_req_vld[idx]) begin
        win_found = 1'b1;
        winner    = idx;
      end
    end
  end

  // Only the granted requester sees ack, and only while the output can load.
  always_comb begin
    din_req_ack = '0;
    if (state == BURST) begin
      din_req_ack[grant] = can_load;
    end
  end

  // Grant state machine: pick a winner in IDLE, count beats in BURST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last  <= LAST_RST;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant <= winner;
            last  <= winner;
            cnt   <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (!grant_vld) begin
            // Requester paused: release the grant so others can go.
            state <= IDLE;
          end else if (accept) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == CNT_MAX) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-entry output register; drains independently of the grant logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_vld  <= 1'b0;
      dout_data <= '0;
      dout_src  <= '0;
    end else if (accept) begin
      dout_vld  <= 1'b1;
      dout_data <= req_data[grant];
      dout_src  <= grant;
    end else if (dout_ack) begin
      dout_vld  <= 1'b0;
    end
  end

`ifdef LEAF_ARB_STATS_EN
  // Free-running count of beats handed to the leaf interface; wraps at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count <= '0;
    end else if (dout_vld && dout_ack) begin
      beat_count <= beat_count + 32'd1;
    end
  end
`endif

endmodule
